// File: rtl/zbus_master.sv
// ZX/Z80-style bus master: runs one I/O or memory read/write cycle per accepted request.
// Optional macro ZBUS_MASTER_INT_EN adds a synchronized, sticky zint_n interrupt flag.
module zbus_master #(
  parameter int unsigned TCLK     = 2,
  parameter int unsigned IO_WAITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        claimed,
  output logic [15:0] za,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic [7:0]  zd_in,
  output logic        ziorq_n,
  output logic        zmreq_n,
  output logic        zrd_n,
  output logic        zwr_n,
  input  logic        ziorqge,
  input  logic        zint_n,
  input  logic        int_clr,
  output logic        int_req
);

  localparam logic [3:0] TclkM1   = 4'(TCLK - 1);
  localparam logic [2:0] WaitsM1  = (IO_WAITS != 0) ? 3'(IO_WAITS - 1) : 3'd0;
  localparam bit         HasWaits = (IO_WAITS != 0);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        claimed_q, claimed_d;

  logic io_q, wr_q, last_tick, in_cycle, strobe;

  assign io_q      = ~op_q[1];
  assign wr_q      = op_q[0];
  assign last_tick = (cnt_q == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      wcnt_q    <= 3'd0;
      op_q      <= 2'b00;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      claimed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      claimed_q <= claimed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    claimed_d = claimed_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = TclkM1;
          state_d = StT1;
        end
      end
      StT1: begin
        if (last_tick) begin
          cnt_d   = TclkM1;
          state_d = StT2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StT2: begin
        if (last_tick) begin
          cnt_d = TclkM1;
          if (io_q && HasWaits) begin
            wcnt_d  = WaitsM1;
            state_d = StTw;
          end else begin
            state_d = StT3;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StTw: begin
        if (last_tick) begin
          cnt_d = TclkM1;
          if (wcnt_q == 3'd0) begin
            state_d = StT3;
          end else begin
            wcnt_d = wcnt_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StT3: begin
        if (last_tick) begin
          // Read data and claim are sampled on the final clock before strobes release.
          if (!wr_q) rdata_d = zd_in;
          if (io_q && !wr_q) claimed_d = ziorqge;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_cycle = (state_q == StT1) || (state_q == StT2) || (state_q == StTw) || (state_q == StT3);
    strobe   = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);
    // The accept clock is an IDLE clock, so busy there follows req directly.
    busy     = (state_q != StIdle) || (req && !rst);
    done     = (state_q == StDone);
    za       = in_cycle ? addr_q : 16'h0000;
    zd_oe    = in_cycle && wr_q;
    zd_out   = (in_cycle && wr_q) ? wdata_q : 8'h00;
    ziorq_n  = ~(strobe && io_q);
    zmreq_n  = ~(strobe && !io_q);
    zrd_n    = ~(strobe && !wr_q);
    zwr_n    = ~(strobe && wr_q);
    rdata    = rdata_q;
    claimed  = claimed_q;
  end

`ifdef ZBUS_MASTER_INT_EN
  logic [1:0] sync_q;
  logic       int_req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      int_req_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], zint_n};
      if (!sync_q[1]) begin
        int_req_q <= 1'b1;
      end else if (int_clr) begin
        int_req_q <= 1'b0;
      end
    end
  end

  assign int_req = int_req_q;
`else
  logic unused_int;
  assign unused_int = zint_n ^ int_clr;
  assign int_req    = 1'b0;
`endif

endmodule

// File: tb/tb_zbus_master.sv
// Bench for zbus_master: spec vector table, back-to-back, mid-cycle reset and random cycles
// checked clock by clock against a timing-window reference model.
module tb_zbus_master;

  localparam int unsigned TCLK     = 2;
  localparam int unsigned IO_WAITS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy, done, claimed, zd_oe;
  logic [7:0]  rdata, zd_out, zd_in;
  logic [15:0] za;
  logic        ziorq_n, zmreq_n, zrd_n, zwr_n;
  logic        ziorqge, zint_n, int_clr, int_req;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_rdata;
  logic       m_claimed;

  zbus_master #(.TCLK(TCLK), .IO_WAITS(IO_WAITS)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .claimed(claimed),
    .za(za), .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in),
    .ziorq_n(ziorq_n), .zmreq_n(zmreq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
    .ziorqge(ziorqge), .zint_n(zint_n), .int_clr(int_clr), .int_req(int_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  zin;
    logic        ge;
    logic [7:0]  exp_rdata;
    logic        exp_claimed;
  } vec_t;

  // {za, zd_out, zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n, busy, done, rdata, claimed}
  function automatic logic [39:0] snap();
    return {za, zd_out, zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n, busy, done, rdata, claimed};
  endfunction

  function automatic logic [39:0] idle_exp(input logic b);
    return {16'h0000, 8'h00, 1'b0, 4'hF, b, 1'b0, m_rdata, m_claimed};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full cycle; k counts clocks after the accept clock (k=0).
  task automatic run_txn(input logic [1:0] t_op, input logic [15:0] t_addr,
                         input logic [7:0] t_wdata, input logic [7:0] t_zin,
                         input logic t_ge, input bit hold, input string name);
    bit         io, wr, dn, act, oe;
    int         len, t;
    logic [7:0] new_rd;
    logic       new_cl;
    logic [39:0] e;
    io = !t_op[1];
    wr = t_op[0];
    len = 1 + TCLK * (3 + (io ? IO_WAITS : 0));
    new_rd = wr ? m_rdata : t_zin;
    new_cl = (io && !wr) ? t_ge : m_claimed;
    @(negedge clk);
    req = 1'b1; op = t_op; addr = t_addr; wdata = t_wdata; zd_in = t_zin; ziorqge = t_ge;
    #1;
    check($sformatf("%s accept", name), snap(), idle_exp(1'b1));
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      #1;
      t   = (k - 1) / TCLK;
      dn  = (k == len);
      act = !dn && (t >= 1);
      oe  = !dn && wr;
      e = {dn ? 16'h0000 : t_addr, oe ? t_wdata : 8'h00, oe,
           !(act && io), !(act && !io), !(act && !wr), !(act && wr),
           1'b1, dn, dn ? new_rd : m_rdata, dn ? new_cl : m_claimed};
      check($sformatf("%s k=%0d", name, k), snap(), e);
    end
    m_rdata = new_rd;
    m_claimed = new_cl;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    #1;
    check(name, snap(), idle_exp(1'b0));
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{2'b01, 16'h00AB, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{2'b00, 16'h80AB, 8'h00, 8'hC3, 1'b1, 8'hC3, 1'b1};
    tbl[2] = '{2'b10, 16'h3FFF, 8'h00, 8'h77, 1'b0, 8'h77, 1'b1};
    tbl[3] = '{2'b11, 16'h1234, 8'hA5, 8'h99, 1'b0, 8'h77, 1'b1};
    tbl[4] = '{2'b00, 16'hFFFF, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0};
    tbl[5] = '{2'b10, 16'h0000, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b0};

    rst = 1'b1; req = 1'b0; op = 2'b00; addr = 16'h0; wdata = 8'h0;
    zd_in = 8'h0; ziorqge = 1'b0; zint_n = 1'b1; int_clr = 1'b0;
    m_rdata = 8'h00; m_claimed = 1'b0;
    #1;
    check("reset state", snap(), idle_exp(1'b0));
    check("reset int_req", {39'd0, int_req}, 40'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("idle after reset");

    foreach (tbl[i]) begin
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].zin, tbl[i].ge, 1'b0,
              $sformatf("tbl%0d", i));
      check_idle($sformatf("tbl%0d idle", i));
      check($sformatf("tbl%0d rdata/claimed", i), {31'd0, rdata, claimed},
            {31'd0, tbl[i].exp_rdata, tbl[i].exp_claimed});
    end

    // Back-to-back with req held high: exactly one IDLE accept clock between cycles.
    run_txn(2'b11, 16'h4000, 8'h11, 8'h00, 1'b0, 1'b1, "b2b0");
    run_txn(2'b00, 16'h00FE, 8'h00, 8'h42, 1'b1, 1'b1, "b2b1");
    run_txn(2'b10, 16'h8000, 8'h00, 8'h24, 1'b0, 1'b0, "b2b2");
    check_idle("b2b idle");

    // Reset while in TW: strobes release on the same edge, no done, then normal operation.
    @(negedge clk);
    req = 1'b1; op = 2'b01; addr = 16'h1111; wdata = 8'h22;
    for (int k = 1; k <= 2 * TCLK + 1; k++) begin
      @(negedge clk);
      req = 1'b0;
    end
    #1;
    check("pre-rst strobes in TW", {36'd0, ziorq_n, zmreq_n, zrd_n, zwr_n}, {36'd0, 4'b0110});
    rst = 1'b1;
    m_rdata = 8'h00; m_claimed = 1'b0;
    #1;
    check("rst in TW", snap(), idle_exp(1'b0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst quiet %0d", k), snap(), idle_exp(1'b0));
    end
    run_txn(2'b00, 16'h5555, 8'h00, 8'hE7, 1'b1, 1'b0, "post-rst");
    check_idle("post-rst idle");

    for (int n = 0; n < 30; n++) begin
      run_txn(2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end
    req = 1'b0;
    check_idle("rnd idle");
    check_idle("rnd idle2");

`ifdef ZBUS_MASTER_INT_EN
    begin
      bit seen;
      @(negedge clk);
      zint_n = 1'b0;
      @(negedge clk);
      zint_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 2 && !seen; k++) begin
        @(negedge clk);
        seen = int_req;
      end
      check("int_req within 3 clks", {39'd0, seen}, {39'd0, 1'b1});
      repeat (3) @(negedge clk);
      check("int_req sticky", {39'd0, int_req}, {39'd0, 1'b1});
      int_clr = 1'b1;
      @(negedge clk);
      int_clr = 1'b0;
      check("int_clr clears", {39'd0, int_req}, 40'd0);
      @(negedge clk);
      zint_n = 1'b0;
      int_clr = 1'b1;
      repeat (4) @(negedge clk);
      check("set wins over clr", {39'd0, int_req}, {39'd0, 1'b1});
      zint_n = 1'b1;
      repeat (3) @(negedge clk);
      check("clr after release", {39'd0, int_req}, 40'd0);
      int_clr = 1'b0;
    end
`else
    @(negedge clk);
    zint_n = 1'b0;
    int_clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("int_req off %0d", k), {39'd0, int_req}, 40'd0);
    end
    zint_n = 1'b1;
    int_clr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/zbus_master.md
ZBUS_MASTER -- requirements
Module: zbus_master

Interface
REQ-001 Parameter TCLK, default 2: clk cycles per Z80 T-state; legal range 1..15.
REQ-002 Parameter IO_WAITS, default 1: TW states inserted in I/O cycles; legal range 0..7; memory cycles have no TW.
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  1  start request; sampled in IDLE only.
REQ-006 op  in  2  cycle type: 00 I/O read, 01 I/O write, 10 memory read, 11 memory write.
REQ-007 addr  in  16  cycle address.
REQ-008 wdata  in  8  write data.
REQ-009 busy  out  1  high from the accept clock until the done clock, inclusive.
REQ-010 done  out  1  one-clk pulse at the end of a cycle.
REQ-011 rdata  out  8  read data; valid from done onward, held until the next read completes.
REQ-012 claimed  out  1  ziorqge was seen high during the last I/O read; held until the next I/O read.
REQ-013 za  out  16  ZX address bus.
REQ-014 zd_out  out  8  ZX data bus, drive value.
REQ-015 zd_oe  out  1  ZX data bus, drive enable.
REQ-016 zd_in  in  8  ZX data bus, sensed value.
REQ-017 ziorq_n, zmreq_n, zrd_n, zwr_n  out  1 each  ZX bus strobes, active-low.
REQ-018 ziorqge  in  1  card claim signal for I/O reads.
REQ-019 zint_n  in  1  ZX interrupt line, asynchronous (used only per REQ-036).
REQ-020 int_clr  in  1  clears int_req (used only per REQ-036).
REQ-021 int_req  out  1  sticky interrupt flag (used only per REQ-036).

Function
REQ-022 FSM states: IDLE, T1, T2, TW, T3, DONE; each T-state (T1, T2, TW, T3) lasts exactly TCLK clocks, timed by a down-counter.
REQ-023 IDLE with req=1 accepts the request: op, addr and wdata are registered and the FSM enters T1 on the next clk; busy rises on the accept clock.
REQ-024 req while busy=1 is ignored; a req held high through DONE is accepted again on the first IDLE clock.
REQ-025 za = latched addr from T1 through T3; za = 16'h0000 in IDLE and DONE.
REQ-026 Strobes assert in T2, TW and T3: zmreq_n or ziorq_n per op, and zrd_n or zwr_n per op; all are high in IDLE, T1 and DONE.
REQ-027 Transitions: T2 goes to TW if op is I/O and IO_WAITS>0, otherwise to T3; TW repeats IO_WAITS times, then goes to T3; T3 goes to DONE; DONE goes to IDLE after 1 clk.
REQ-028 Writes: zd_oe=1 and zd_out=wdata from T1 through T3; zd_oe=0 in all other states and on all reads.
REQ-029 Reads: rdata captures zd_in on the last clk of T3.
REQ-030 I/O reads: claimed is set to ziorqge sampled on the last clk of T3.
REQ-031 done=1 only in DONE.
REQ-032 Cycle length in clocks, accept to done inclusive = 1 + TCLK*(3 + W) + 1, where W = IO_WAITS for I/O cycles and 0 for memory cycles.

Reset
REQ-033 rst asserted forces immediately: FSM=IDLE; strobes high; zd_oe=0; za, zd_out, rdata = 0; busy, done, claimed, int_req = 0.
REQ-034 rst asserted mid-cycle aborts the cycle with no done pulse; the first req after rst deasserts is accepted normally.

Configuration
REQ-035 Macro ZBUS_MASTER_INT_EN selects the interrupt logic.
REQ-036 With ZBUS_MASTER_INT_EN defined: zint_n passes through a 2-flop synchronizer; a synchronized low sets int_req; int_clr=1 clears int_req; if set and clear occur together, set wins.
REQ-037 Without ZBUS_MASTER_INT_EN: int_req is constant 0; zint_n and int_clr are unused.

Verification
REQ-038 TCLK=2, IO_WAITS=1: I/O write op=01, addr=16'h00AB, wdata=8'h5A -> za=00AB and zd_out=5A with zd_oe=1 for 8 clks; ziorq_n and zwr_n low for 6 clks; done on clk 10 after accept.
REQ-039 I/O read op=00, addr=16'h80AB; bench drives zd_in=8'hC3 and ziorqge=1 -> rdata=C3, claimed=1, zd_oe never asserted.
REQ-040 Memory read op=10, addr=16'h3FFF, zd_in=8'h77 -> zmreq_n and zrd_n low 4 clks, no TW, rdata=77, done on clk 8.
REQ-041 rst pulsed while in TW -> all strobes high and zd_oe=0 on the same edge, no done; the next request completes normally.
REQ-042 req held high continuously -> back-to-back cycles with exactly one IDLE clock between done and the next T1.
REQ-043 With ZBUS_MASTER_INT_EN: zint_n low 1 clk -> int_req=1 within 3 clks; int_clr and a new zint_n low together -> int_req stays 1; without the macro -> int_req stays 0.
